cal_flags_seq: RTL and testbench

CAL_FLAGS_SEQ -- requirements
Module: cal_flags_seq

---
 rtl/cal_flags_seq_pkg.sv | 22 ++
 rtl/cal_flags_seq_if.sv | 38 +++
 rtl/flag_stack.sv | 71 +++++++
 rtl/cal_flags_seq.sv | 97 +++++++++
 tb/tb_cal_flags_seq.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cal_flags_seq_pkg.sv
// Shared types for the NZCV flag sequencer: opcodes, FSM encoding, flag-vector layout.
package cal_flags_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b110;
  localparam logic [2:0] OP_SUB = 3'b111;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StUpdate  = 2'd1,
    StRestore = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  localparam nzcv_t FLAGS_RST = '{n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0};

endpackage

// File: rtl/cal_flags_seq_if.sv
// Bus between the ALU-side producer (master) and the flag sequencer (slave).
interface cal_flags_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
);
  logic                       in_valid;
  logic [2:0]                 op;
  logic [WIDTH-1:0]           result;
  logic                       co_add;
  logic                       cm_add;
  logic                       co_sub;
  logic                       cm_sub;
  logic                       push;
  logic                       pop;
  logic                       clr_sticky;
  logic                       c;
  logic                       n;
  logic                       z;
  logic                       v;
  logic                       v_sticky;
  logic [CNT_W-1:0]           ovf_cnt;
  logic                       out_valid;
  logic [$clog2(DEPTH+1)-1:0] stk_depth;
  logic                       stk_full;
  logic                       stk_empty;
  logic                       stk_err;

  modport master (
    output in_valid, op, result, co_add, cm_add, co_sub, cm_sub, push, pop, clr_sticky,
    input  c, n, z, v, v_sticky, ovf_cnt, out_valid, stk_depth, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  in_valid, op, result, co_add, cm_add, co_sub, cm_sub, push, pop, clr_sticky,
    output c, n, z, v, v_sticky, ovf_cnt, out_valid, stk_depth, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/flag_stack.sv
// LIFO of NZCV vectors with combinational top read, push/pop swap and sticky error.
module flag_stack
  import cal_flags_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  nzcv_t                      i_wdata,
  output nzcv_t                      o_rdata,
  output logic                       o_pop_ok,
  output logic [$clog2(DEPTH+1)-1:0] o_depth,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_err
);
  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  nzcv_t           r_mem [DEPTH];
  logic [DW-1:0]   r_depth;
  logic            r_err;
  logic [AW-1:0]   w_top_idx;
  logic [AW-1:0]   w_wr_idx;
  logic            w_empty;
  logic            w_full;

  assign w_empty   = (r_depth == '0);
  assign w_full    = (r_depth == DW'(DEPTH));
  assign w_top_idx = AW'(r_depth - DW'(1));
  assign w_wr_idx  = AW'(r_depth);

  assign o_rdata  = r_mem[w_top_idx];
  assign o_pop_ok = i_pop & ~w_empty;
  assign o_depth  = r_depth;
  assign o_full   = w_full;
  assign o_empty  = w_empty;
  assign o_err    = r_err;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_pop && !w_empty && i_push) begin
      r_mem[w_top_idx] <= i_wdata;
    end else if (i_push && !i_pop && !w_full) begin
      r_mem[w_wr_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (i_pop) begin
      // Push+pop on an empty stack is an underflow, not a push.
      if (w_empty) begin
        r_err <= 1'b1;
      end else if (!i_push) begin
        r_depth <= r_depth - DW'(1);
      end
    end else if (i_push) begin
      if (w_full) begin
        r_err <= 1'b1;
      end else begin
        r_depth <= r_depth + DW'(1);
      end
    end
  end

endmodule

// File: rtl/cal_flags_seq.sv
// NZCV flag register with overflow tracking and a save/restore flag stack.
module cal_flags_seq
  import cal_flags_seq_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = 8,
  parameter bit          PRESERVE_CV = 1'b1
) (
  input logic           clk,
  input logic           reset,
  cal_flags_seq_if.slave bus
);
  nzcv_t            r_flags;
  nzcv_t            w_eval;
  nzcv_t            w_top;
  state_e           r_state;
  logic             r_v_sticky;
  logic [CNT_W-1:0] r_ovf_cnt;
  logic             w_pop_ok;
  logic             w_update;

  flag_stack #(
    .DEPTH(DEPTH)
  ) u_flag_stack (
    .clk      (clk),
    .rst      (reset),
    .i_push   (bus.push),
    .i_pop    (bus.pop),
    .i_wdata  (r_flags),
    .o_rdata  (w_top),
    .o_pop_ok (w_pop_ok),
    .o_depth  (bus.stk_depth),
    .o_full   (bus.stk_full),
    .o_empty  (bus.stk_empty),
    .o_err    (bus.stk_err)
  );

  always_comb begin
    w_eval.n = bus.result[WIDTH-1];
    w_eval.z = ~|bus.result;
    w_eval.c = PRESERVE_CV ? r_flags.c : 1'b0;
    w_eval.v = PRESERVE_CV ? r_flags.v : 1'b0;
    if (bus.op == OP_ADD) begin
      w_eval.c = bus.co_add;
      w_eval.v = bus.co_add ^ bus.cm_add;
    end else if (bus.op == OP_SUB) begin
      w_eval.c = bus.co_sub;
      w_eval.v = bus.co_sub ^ bus.cm_sub;
    end
  end

  // A pop wins over a same-cycle update.
  assign w_update = bus.in_valid & ~bus.pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags    <= FLAGS_RST;
      r_state    <= StIdle;
      r_v_sticky <= 1'b0;
      r_ovf_cnt  <= '0;
    end else begin
      if (bus.pop) begin
        r_state <= StRestore;
        if (w_pop_ok) begin
          r_flags <= w_top;
        end
      end else if (bus.in_valid) begin
        r_state <= StUpdate;
        r_flags <= w_eval;
      end else begin
        r_state <= StIdle;
      end

      if (w_update && w_eval.v) begin
        r_v_sticky <= 1'b1;
        if (bus.clr_sticky) begin
          r_ovf_cnt <= CNT_W'(1);
        end else if (!(&r_ovf_cnt)) begin
          r_ovf_cnt <= r_ovf_cnt + CNT_W'(1);
        end
      end else if (bus.clr_sticky) begin
        r_v_sticky <= 1'b0;
        r_ovf_cnt  <= '0;
      end
    end
  end

  assign bus.n         = r_flags.n;
  assign bus.z         = r_flags.z;
  assign bus.c         = r_flags.c;
  assign bus.v         = r_flags.v;
  assign bus.v_sticky  = r_v_sticky;
  assign bus.ovf_cnt   = r_ovf_cnt;
  assign bus.out_valid = (r_state == StUpdate);

endmodule

// File: tb/tb_cal_flags_seq.sv
// Self-checking bench for cal_flags_seq: directed scenarios plus randomized traffic vs a model.
module tb_cal_flags_seq;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cal_flags_seq_if #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) bus ();

  cal_flags_seq #(
    .WIDTH      (W),
    .DEPTH      (D),
    .CNT_W      (CW),
    .PRESERVE_CV(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: flags as {n,z,c,v}, stack as a queue (back = top).
  logic [3:0]  m_flags;
  logic        m_sticky;
  logic [1:0]  m_cnt;
  logic        m_ov;
  logic        m_err;
  logic [3:0]  m_stk[$];

  function automatic void model_reset();
    m_flags  = 4'b0100;
    m_sticky = 1'b0;
    m_cnt    = 2'd0;
    m_ov     = 1'b0;
    m_err    = 1'b0;
    m_stk.delete();
  endfunction

  function automatic void model_step(input logic iv, input logic [2:0] op,
                                     input logic [7:0] res, input logic [3:0] cy,
                                     input logic ps, input logic pp, input logic cl);
    logic [3:0] top;
    logic       nc;
    logic       nv;
    logic       upd;
    upd = iv && !pp;
    if (pp) begin
      if (m_stk.size() > 0) begin
        top = m_stk[m_stk.size()-1];
        if (ps) m_stk[m_stk.size()-1] = m_flags;
        else void'(m_stk.pop_back());
        m_flags = top;
      end else begin
        m_err = 1'b1;
      end
    end else if (ps) begin
      if (m_stk.size() == D) m_err = 1'b1;
      else m_stk.push_back(m_flags);
    end
    m_ov = upd;
    if (upd) begin
      nc = m_flags[1];
      nv = m_flags[0];
      if (op == 3'b110) begin
        nc = cy[3];
        nv = cy[3] ^ cy[2];
      end else if (op == 3'b111) begin
        nc = cy[1];
        nv = cy[1] ^ cy[0];
      end
      m_flags = {res[7], res == 8'h00, nc, nv};
    end
    if (upd && m_flags[0]) begin
      m_sticky = 1'b1;
      if (cl) m_cnt = 2'd1;
      else if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    end else if (cl) begin
      m_sticky = 1'b0;
      m_cnt    = 2'd0;
    end
  endfunction

  function automatic logic [13:0] expv();
    logic [2:0] d;
    d = 3'(m_stk.size());
    return {m_flags, m_sticky, m_cnt, m_ov, d, d == 3'd4, d == 3'd0, m_err};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.n, bus.z, bus.c, bus.v, bus.v_sticky, bus.ovf_cnt, bus.out_valid,
            bus.stk_depth, bus.stk_full, bus.stk_empty, bus.stk_err};
  endfunction

  // cy = {co_add, cm_add, co_sub, cm_sub}
  task automatic drive(input logic iv, input logic [2:0] op, input logic [7:0] res,
                       input logic [3:0] cy, input logic ps, input logic pp, input logic cl);
    bus.in_valid   = iv;
    bus.op         = op;
    bus.result     = res;
    {bus.co_add, bus.cm_add, bus.co_sub, bus.cm_sub} = cy;
    bus.push       = ps;
    bus.pop        = pp;
    bus.clr_sticky = cl;
    model_step(iv, op, res, cy, ps, pp, cl);
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.clr_sticky = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (obs() !== 14'b0100_0_00_0_000_0_1_0) begin
      n_bad++;
      $display("FAIL reset_state: got %b expected %b", obs(), 14'b0100_0_00_0_000_0_1_0);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 3'b110, 8'h80, 4'b0100, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({bus.n, bus.z, bus.c, bus.v, bus.v_sticky, bus.ovf_cnt, bus.out_valid}
        !== {4'b1001, 1'b1, 2'd1, 1'b1}) begin
      n_bad++;
      $display("FAIL add_flags: got %b expected %b",
               {bus.n, bus.z, bus.c, bus.v, bus.v_sticky, bus.ovf_cnt, bus.out_valid},
               {4'b1001, 1'b1, 2'd1, 1'b1});
    end
    drive(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs() !== expv()) begin
      n_bad++;
      $display("FAIL add_idle_hold: got %b expected %b", obs(), expv());
    end
  endtask

  task automatic test_sub_logic();
    drive(1'b1, 3'b111, 8'h00, 4'b0011, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({bus.n, bus.z, bus.c, bus.v} !== 4'b0110) begin
      n_bad++;
      $display("FAIL sub_flags: got %b expected %b", {bus.n, bus.z, bus.c, bus.v}, 4'b0110);
    end
    drive(1'b1, 3'b000, 8'h01, 4'b1111, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if ({bus.n, bus.z, bus.c, bus.v, bus.out_valid} !== 5'b0010_1) begin
      n_bad++;
      $display("FAIL logic_hold_cv: got %b expected %b",
               {bus.n, bus.z, bus.c, bus.v, bus.out_valid}, 5'b0010_1);
    end
  endtask

  task automatic test_stack();
    logic [3:0] saved[5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      saved[i] = m_flags;
      drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 4'($urandom), 1'b1, 1'b0, 1'b0);
    end
    n_vec++;
    if ({bus.stk_depth, bus.stk_full, bus.stk_err} !== {3'd4, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL stack_full: got %b expected %b",
               {bus.stk_depth, bus.stk_full, bus.stk_err}, {3'd4, 1'b1, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0);
      n_vec++;
      if ({bus.n, bus.z, bus.c, bus.v} !== saved[3-i] || obs() !== expv()) begin
        n_bad++;
        $display("FAIL stack_pop%0d: got %b expected flags %b vec %b",
                 i, obs(), saved[3-i], expv());
      end
    end
    drive(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if ({bus.n, bus.z, bus.c, bus.v} !== saved[0] || obs() !== expv()) begin
      n_bad++;
      $display("FAIL stack_underflow: got %b expected vec %b", obs(), expv());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b110, 8'($urandom), 4'b1000, 1'b0, 1'b0, 1'b0);
    end
    n_vec++;
    if ({bus.v_sticky, bus.ovf_cnt} !== 3'b1_11) begin
      n_bad++;
      $display("FAIL ovf_saturate: got %b expected %b", {bus.v_sticky, bus.ovf_cnt}, 3'b1_11);
    end
    drive(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({bus.v_sticky, bus.ovf_cnt} !== 3'b0_00) begin
      n_bad++;
      $display("FAIL clr_sticky: got %b expected %b", {bus.v_sticky, bus.ovf_cnt}, 3'b0_00);
    end
    drive(1'b1, 3'b110, 8'h40, 4'b1000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 8'h40, 4'b0001, 1'b0, 1'b0, 1'b1);
    n_vec++;
    if ({bus.v_sticky, bus.ovf_cnt} !== 3'b1_01 || obs() !== expv()) begin
      n_bad++;
      $display("FAIL clr_vs_update: got %b expected %b", obs(), expv());
    end
  endtask

  task automatic test_priority();
    do_reset();
    drive(1'b0, 3'b000, 8'h00, 4'b0000, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if ({bus.stk_depth, bus.stk_err, bus.z} !== {3'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL pushpop_empty: got %b expected %b",
               {bus.stk_depth, bus.stk_err, bus.z}, {3'd0, 1'b1, 1'b1});
    end
    drive(1'b1, 3'b110, 8'h80, 4'b1100, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 8'h00, 4'b0011, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b000, 8'h05, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 4'b0000, 1'b1, 1'b1, 1'b0);
    n_vec++;
    if (bus.stk_depth !== 3'd2 || {bus.n, bus.z, bus.c, bus.v} !== 4'b1010
        || obs() !== expv()) begin
      n_bad++;
      $display("FAIL pushpop_swap: got %b expected %b", obs(), expv());
    end
    drive(1'b1, 3'b110, 8'h00, 4'b1000, 1'b0, 1'b1, 1'b0);
    n_vec++;
    if (bus.out_valid !== 1'b0 || obs() !== expv()) begin
      n_bad++;
      $display("FAIL pop_over_update: got %b expected %b", obs(), expv());
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      drive(1'($urandom_range(0, 3) != 0), op, 8'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0));
      n_vec++;
      if (obs() !== expv()) begin
        n_bad++;
        $display("FAIL random_%0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b110, 8'($urandom), 4'b1000, 1'b1, 1'b0, 1'b0);
    end
    bus.in_valid = 1'b1;
    bus.push     = 1'b1;
    bus.op       = 3'b110;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (obs() !== 14'b0100_0_00_0_000_0_1_0) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected %b", obs(), 14'b0100_0_00_0_000_0_1_0);
    end
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.push     = 1'b0;
    drive(1'b0, 3'b000, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    n_vec++;
    if (obs() !== expv()) begin
      n_bad++;
      $display("FAIL after_reset: got %b expected %b", obs(), expv());
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.op         = 3'b000;
    bus.result     = '0;
    bus.co_add     = 1'b0;
    bus.cm_add     = 1'b0;
    bus.co_sub     = 1'b0;
    bus.cm_sub     = 1'b0;
    bus.push       = 1'b0;
    bus.pop        = 1'b0;
    bus.clr_sticky = 1'b0;
    test_reset();
    test_add();
    test_sub_logic();
    test_stack();
    test_saturation();
    test_priority();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
